// File: rtl/mem_bus_arbiter.sv
// Shared data-memory port arbiter for two L1 caches: one transaction at a time, round-robin.
// Optional MEMBUS_WRITE_PRIO_EN: on an IDLE conflict a write beats a read.
module mem_bus_arbiter #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 32,
   parameter int unsigned RW = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [RW-1:0] rwFromCacheA,
   input  logic [AW-1:0] addrFromCacheA,
   input  logic [DW-1:0] dataFromCacheA,
   output logic [DW-1:0] dataToCacheA,
   output logic          rdEnToCacheA,
   output logic          wbDoneToCacheA,
   input  logic [RW-1:0] rwFromCacheB,
   input  logic [AW-1:0] addrFromCacheB,
   input  logic [DW-1:0] dataFromCacheB,
   output logic [DW-1:0] dataToCacheB,
   output logic          rdEnToCacheB,
   output logic          wbDoneToCacheB,
   output logic          memReq,
   output logic          memWe,
   output logic [AW-1:0] memAddr,
   output logic [DW-1:0] memWData,
   input  logic [DW-1:0] memRData,
   input  logic          memAck,
   output logic          grantA,
   output logic          grantB
);

   localparam logic [RW-1:0] RwRead  = RW'(1);
   localparam logic [RW-1:0] RwWrite = RW'(2);

   typedef enum logic [1:0] {StIdle, StIssue, StResp, StRelease} state_e;

   state_e        state_q;
   logic          last_b_q;
   logic          mem_req_q, mem_we_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q, data_a_q, data_b_q;
   logic          rd_en_a_q, rd_en_b_q, wb_done_a_q, wb_done_b_q;
   logic          grant_a_q, grant_b_q;

   logic wr_a, wr_b, req_a, req_b, win_b, owner_idle;

   assign wr_a  = (rwFromCacheA == RwWrite);
   assign wr_b  = (rwFromCacheB == RwWrite);
   assign req_a = wr_a || (rwFromCacheA == RwRead);
   assign req_b = wr_b || (rwFromCacheB == RwRead);

   always_comb begin
      win_b = req_b;
      if (req_a && req_b) begin
`ifdef MEMBUS_WRITE_PRIO_EN
         if (wr_a != wr_b) win_b = wr_b;
         else              win_b = !last_b_q;
`else
         win_b = !last_b_q;
`endif
      end
   end

   // Owner must drop its request before the port is released, blocking double service.
   assign owner_idle = grant_b_q ? !req_b : !req_a;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= StIdle;
         last_b_q    <= 1'b1;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         data_a_q    <= '0;
         data_b_q    <= '0;
         rd_en_a_q   <= 1'b0;
         rd_en_b_q   <= 1'b0;
         wb_done_a_q <= 1'b0;
         wb_done_b_q <= 1'b0;
         grant_a_q   <= 1'b0;
         grant_b_q   <= 1'b0;
      end else begin
         rd_en_a_q   <= 1'b0;
         rd_en_b_q   <= 1'b0;
         wb_done_a_q <= 1'b0;
         wb_done_b_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req_a || req_b) begin
                  grant_a_q   <= !win_b;
                  grant_b_q   <= win_b;
                  mem_we_q    <= win_b ? wr_b : wr_a;
                  mem_addr_q  <= win_b ? addrFromCacheB : addrFromCacheA;
                  mem_wdata_q <= win_b ? dataFromCacheB : dataFromCacheA;
                  mem_req_q   <= 1'b1;
                  state_q     <= StIssue;
               end
            end
            StIssue: begin
               if (memAck) begin
                  mem_req_q <= 1'b0;
                  state_q   <= StResp;
                  if (mem_we_q) begin
                     wb_done_a_q <= grant_a_q;
                     wb_done_b_q <= grant_b_q;
                  end else if (grant_b_q) begin
                     rd_en_b_q <= 1'b1;
                     data_b_q  <= memRData;
                  end else begin
                     rd_en_a_q <= 1'b1;
                     data_a_q  <= memRData;
                  end
               end
            end
            StResp: state_q <= StRelease;
            StRelease: begin
               if (owner_idle) begin
                  last_b_q  <= grant_b_q;
                  grant_a_q <= 1'b0;
                  grant_b_q <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign memReq         = mem_req_q;
   assign memWe          = mem_we_q;
   assign memAddr        = mem_addr_q;
   assign memWData       = mem_wdata_q;
   assign dataToCacheA   = data_a_q;
   assign dataToCacheB   = data_b_q;
   assign rdEnToCacheA   = rd_en_a_q;
   assign rdEnToCacheB   = rd_en_b_q;
   assign wbDoneToCacheA = wb_done_a_q;
   assign wbDoneToCacheB = wb_done_b_q;
   assign grantA         = grant_a_q;
   assign grantB         = grant_b_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle vector table plus reset and priority sequences.
module tb_mem_bus_arbiter;

   localparam logic [31:0] DA = 32'hAAAA0001;
   localparam logic [31:0] DB = 32'h12345678;
`ifdef MEMBUS_WRITE_PRIO_EN
   localparam bit PrioB = 1'b1;
`else
   localparam bit PrioB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  rwA, rwB;
   logic [7:0]  addrA, addrB, memAddr;
   logic [31:0] dinA, dinB, doutA, doutB, memWData, memRData;
   logic        rdA, rdB, wbA, wbB, memReq, memWe, memAck, grantA, grantB;

   int n_cmp = 0;
   int n_fail = 0;

   mem_bus_arbiter dut (
      .clk(clk), .reset(reset),
      .rwFromCacheA(rwA), .addrFromCacheA(addrA), .dataFromCacheA(dinA),
      .dataToCacheA(doutA), .rdEnToCacheA(rdA), .wbDoneToCacheA(wbA),
      .rwFromCacheB(rwB), .addrFromCacheB(addrB), .dataFromCacheB(dinB),
      .dataToCacheB(doutB), .rdEnToCacheB(rdB), .wbDoneToCacheB(wbB),
      .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
      .memRData(memRData), .memAck(memAck), .grantA(grantA), .grantB(grantB)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  rwa, rwb;
      logic        ack;
      logic [31:0] rd;
      logic        req, we;
      logic [7:0]  addr;
      logic [31:0] wd;
      logic        ga, gb, ra, rb, wa, wb;
      logic [31:0] da, db;
   } vec_t;

   function automatic vec_t mk(logic [1:0] rwa, logic [1:0] rwb, logic ack, logic [31:0] rd,
                               logic req, logic we, logic [7:0] addr, logic [31:0] wd,
                               logic ga, logic gb, logic ra, logic rb, logic wa, logic wb,
                               logic [31:0] da, logic [31:0] db);
      vec_t v;
      v.rwa = rwa; v.rwb = rwb; v.ack = ack; v.rd = rd;
      v.req = req; v.we = we; v.addr = addr; v.wd = wd;
      v.ga = ga; v.gb = gb; v.ra = ra; v.rb = rb; v.wa = wa; v.wb = wb;
      v.da = da; v.db = db;
      return v;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [111:0] got, input logic [111:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [111:0] all_outs();
      return {memReq, memWe, memAddr, memWData, grantA, grantB, rdA, rdB, wbA, wbB,
              doutA, doutB};
   endfunction

   // Bus fields are only meaningful while memReq is expected high.
   task automatic chk_vec(input string name, input vec_t v);
      logic [111:0] got, exp;
      got = {memReq, v.req ? memWe : 1'b0, v.req ? memAddr : 8'h0, v.req ? memWData : 32'h0,
             grantA, grantB, rdA, rdB, wbA, wbB, doutA, doutB};
      exp = {v.req, v.req ? v.we : 1'b0, v.req ? v.addr : 8'h0, v.req ? v.wd : 32'h0,
             v.ga, v.gb, v.ra, v.rb, v.wa, v.wb, v.da, v.db};
      chk(name, got, exp);
   endtask

   // A read vs B write; exp_b says which port must win.
   task automatic conflict(input string name, input bit exp_b);
      rwA = 2'b01; rwB = 2'b10; memAck = 1'b0;
      cyc();
      chk({name, "_grant"}, {110'd0, grantA, grantB}, {110'd0, !exp_b, exp_b});
      chk({name, "_we"}, {111'd0, memWe}, {111'd0, exp_b});
      memAck = 1'b1; memRData = 32'hCAFE0000;
      cyc();
      chk({name, "_pulse"}, {108'd0, rdA, rdB, wbA, wbB}, {108'd0, !exp_b, 1'b0, 1'b0, exp_b});
      memAck = 1'b0; rwA = 2'b00; rwB = 2'b00;
      cyc();
      cyc();
   endtask

   vec_t tbl[22];

   initial begin
      addrA = 8'h10; addrB = 8'h22; dinA = DA; dinB = DB;
      rwA = 2'b01; rwB = 2'b00; memAck = 1'b0; memRData = '0; reset = 1'b0;

      tbl[0]  = mk(1, 0, 0, 0,            1, 0, 8'h10, DA, 1, 0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 0, 0, 0,            1, 0, 8'h10, DA, 1, 0, 0, 0, 0, 0, 0, 0);
      tbl[2]  = mk(1, 0, 0, 0,            1, 0, 8'h10, DA, 1, 0, 0, 0, 0, 0, 0, 0);
      tbl[3]  = mk(1, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 32'hDEADBEEF, 0);
      tbl[4]  = mk(1, 0, 0, 0,            0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0);
      tbl[5]  = mk(1, 0, 0, 0,            0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0);
      tbl[6]  = mk(0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0);
      tbl[7]  = mk(1, 1, 0, 0,            1, 0, 8'h22, DB, 0, 1, 0, 0, 0, 0, 32'hDEADBEEF, 0);
      tbl[8]  = mk(1, 1, 1, 32'h0BBB0002, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 32'hDEADBEEF,
                   32'h0BBB0002);
      tbl[9]  = mk(1, 1, 0, 0,            0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'hDEADBEEF,
                   32'h0BBB0002);
      tbl[10] = mk(1, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF,
                   32'h0BBB0002);
      tbl[11] = mk(1, 0, 0, 0,            1, 0, 8'h10, DA, 1, 0, 0, 0, 0, 0, 32'hDEADBEEF,
                   32'h0BBB0002);
      tbl[12] = mk(1, 0, 1, 32'h11112222, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 32'h11112222,
                   32'h0BBB0002);
      tbl[13] = mk(0, 0, 0, 0,            0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h11112222,
                   32'h0BBB0002);
      tbl[14] = mk(0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h11112222,
                   32'h0BBB0002);
      tbl[15] = mk(0, 2, 0, 0,            1, 1, 8'h22, DB, 0, 1, 0, 0, 0, 0, 32'h11112222,
                   32'h0BBB0002);
      tbl[16] = mk(0, 2, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h11112222,
                   32'h0BBB0002);
      tbl[17] = mk(0, 2, 0, 0,            0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h11112222,
                   32'h0BBB0002);
      tbl[18] = mk(0, 2, 0, 0,            0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h11112222,
                   32'h0BBB0002);
      tbl[19] = mk(0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h11112222,
                   32'h0BBB0002);
      tbl[20] = mk(0, 0, 1, 0,            0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h11112222,
                   32'h0BBB0002);
      tbl[21] = mk(3, 3, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h11112222,
                   32'h0BBB0002);

      // Reset held with A requesting: everything stays zero.
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk($sformatf("reset_hold_%0d", i), all_outs(), 112'd0);
      end
      reset = 1'b1; rwA = 2'b00;
      cyc();
      chk("idle_after_reset", all_outs(), 112'd0);

      for (int i = 0; i < 22; i++) begin
         rwA = tbl[i].rwa; rwB = tbl[i].rwb; memAck = tbl[i].ack; memRData = tbl[i].rd;
         cyc();
         chk_vec($sformatf("vec_%0d", i), tbl[i]);
      end
      rwA = 2'b00; rwB = 2'b00; memAck = 1'b0;

      // Reset while in ISSUE discards the transaction; a late ack is ignored.
      rwA = 2'b01;
      cyc();
      chk("mid_issue_req", {111'd0, memReq}, {111'd1, 1'b1} >> 1);
      reset = 1'b0;
      cyc();
      chk("mid_reset_clear", all_outs(), 112'd0);
      reset = 1'b1; rwA = 2'b00; memAck = 1'b1;
      cyc();
      chk("late_ack_ignored", all_outs(), 112'd0);
      memAck = 1'b0; rwB = 2'b01;
      cyc();
      chk("idle_after_mid_reset", {110'd0, grantB, memReq}, {110'd0, 1'b1, 1'b1});
      memAck = 1'b1; memRData = 32'h55AA55AA;
      cyc();
      chk("post_reset_read", {79'd0, rdB, doutB}, {79'd0, 1'b1, 32'h55AA55AA});
      memAck = 1'b0; rwB = 2'b00;
      cyc();
      cyc();

      // lastGrant=B here: write priority picks B, plain round-robin picks A.
      conflict("prio_last_b", PrioB);
      // Solo A read so lastGrant=A, then B must win in either build.
      rwA = 2'b01;
      cyc();
      memAck = 1'b1;
      cyc();
      chk("solo_a_pulse", {111'd0, rdA}, {111'd0, 1'b1});
      memAck = 1'b0; rwA = 2'b00;
      cyc();
      cyc();
      conflict("prio_last_a", 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
